sample_playback_reader: RTL and testbench

SAMPLE_PLAYBACK_READER -- requirements
Module: sample_playback_reader

---
 rtl/sample_playback_reader_pkg.sv | 22 ++
 rtl/sample_playback_reader_if.sv | 42 ++++
 rtl/sample_playback_reader_pair_address_counter.sv | 41 ++++
 rtl/sample_playback_reader.sv | 111 +++++++++++
 tb/tb_sample_playback_reader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_playback_reader_pkg.sv
// Shared types and defaults for the stereo sample playback reader.
// Holds the fetch FSM states and the default geometry of the sample store.
package sample_playback_reader_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  localparam logic [14:0] LAST_EVEN_DEF = 15'd29400;

  typedef enum logic [2:0] {
    IDLE,
    RD_L,
    RD_R,
    CAP_R,
    PRESENT
  } state_t;

  function automatic logic is_read(state_t s);
    return (s == RD_L) || (s == RD_R);
  endfunction

endpackage

// File: rtl/sample_playback_reader_if.sv
// Sample memory read port plus the stereo pair valid/ready stream.
// master = reader side, slave = memory/consumer side.
interface sample_playback_reader_if
  import sample_playback_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;
  logic              out_valid;
  logic              out_ready;
  logic              wrap;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    output out_left,
    output out_right,
    output out_valid,
    input  out_ready,
    output wrap
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    input  out_left,
    input  out_right,
    input  out_valid,
    output out_ready,
    input  wrap
  );

endinterface

// File: rtl/sample_playback_reader_pair_address_counter.sv
// Even-stepping base address for interleaved L/R sample pairs.
// Steps by 2 on inc and returns to 0 after the last even address.
module pair_address_counter
  import sample_playback_reader_pkg::*;
#(
  parameter int              ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] LAST_EVEN =
    ADDR_W'(LAST_EVEN_DEF)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] base,
  output logic              at_last
);

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_base_nxt;
  logic              w_at_last;

  assign w_at_last = (r_base == LAST_EVEN);

  always_comb begin
    w_base_nxt = r_base + ADDR_W'(2);
    if (w_at_last) begin
      w_base_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_base <= '0;
    end else if (inc) begin
      r_base <= w_base_nxt;
    end
  end

  assign base    = r_base;
  assign at_last = w_at_last;

endmodule

// File: rtl/sample_playback_reader.sv
// Fetches one left/right sample pair per transfer from a 1-cycle-latency
// memory and presents it on a valid/ready stream, wrapping at LAST_EVEN.
module sample_playback_reader
  import sample_playback_reader_pkg::*;
#(
  parameter int              ADDR_W    = ADDR_W_DEF,
  parameter int              DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] LAST_EVEN =
    ADDR_W'(LAST_EVEN_DEF)
) (
  input  logic clk,
  input  logic clear,
  input  logic EN,
  sample_playback_reader_if.master bus
);

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_left;
  logic [DATA_W-1:0] r_right;

  logic [ADDR_W-1:0] w_base;
  logic              w_at_last;
  logic              w_sel_hi;
  logic              w_cap_l;
  logic              w_cap_r;
  logic              w_xfer;
  logic              w_valid;

  pair_address_counter #(
    .ADDR_W    (ADDR_W),
    .LAST_EVEN (LAST_EVEN)
  ) u_base (
    .clk     (clk),
    .clear   (clear),
    .inc     (w_xfer),
    .base    (w_base),
    .at_last (w_at_last)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read data lags mem_rd by one cycle, so each capture sits one state late.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_hi    = 1'b0;
    w_cap_l     = 1'b0;
    w_cap_r     = 1'b0;
    w_xfer      = 1'b0;
    w_valid     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (EN) begin
          w_state_nxt = RD_L;
        end
      end
      RD_L: begin
        w_state_nxt = RD_R;
      end
      RD_R: begin
        w_sel_hi    = 1'b1;
        w_cap_l     = 1'b1;
        w_state_nxt = CAP_R;
      end
      CAP_R: begin
        w_cap_r     = 1'b1;
        w_state_nxt = PRESENT;
      end
      PRESENT: begin
        w_valid = 1'b1;
        if (bus.out_ready) begin
          w_xfer      = 1'b1;
          w_state_nxt = EN ? RD_L : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_left  <= '0;
      r_right <= '0;
    end else begin
      if (w_cap_l) begin
        r_left <= bus.mem_rdata;
      end
      if (w_cap_r) begin
        r_right <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = w_sel_hi ? (w_base + ADDR_W'(1))
                                  : w_base;
  assign bus.mem_rd    = is_read(r_state);
  assign bus.out_left  = r_left;
  assign bus.out_right = r_right;
  assign bus.out_valid = w_valid;
  assign bus.wrap      = w_xfer & w_at_last;

endmodule

// File: tb/tb_sample_playback_reader.sv
// Scoreboard bench for sample_playback_reader with LAST_EVEN shrunk to 6.
// Expected pairs come from base = 2k mod (LAST_EVEN+2) over a memory array.
module tb_sample_playback_reader;
  import sample_playback_reader_pkg::*;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam logic [AW-1:0] LE = 15'd6;

  logic clk = 1'b0;
  logic clear;
  logic EN;

  sample_playback_reader_if #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) sif ();

  sample_playback_reader #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .LAST_EVEN (LE)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .EN    (EN),
    .bus   (sif.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] word [0:255];

  always @(posedge clk) begin
    if (sif.mem_rd) begin
      sif.mem_rdata <= word[sif.mem_addr[7:0]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int base;
    bit wr;
  } pair_t;

  pair_t exp_q[$];
  int    k = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic pair_t model(int idx);
    pair_t p;
    p.base = (2 * idx) % (int'(LE) + 2);
    p.wr   = (p.base == int'(LE));
    return p;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(model(k));
      k++;
    end
  endtask

  // Monitor: pops the scoreboard on every accepted pair.
  bit            prev_pres = 0;
  bit            prev_xfer = 0;
  bit            prev_en   = 0;
  logic [DW-1:0] prev_l, prev_r;
  int            next_base = 0;
  pair_t         e;

  always @(negedge clk) begin
    if (clear) begin
      exp_q.delete();
      k = 0;
      prev_pres = 0;
      prev_xfer = 0;
      refill();
    end else begin
      chk("addr_range",
          32'(32'(sif.mem_addr) <= int'(LE) + 1), 32'd1);
      if (sif.out_valid)
        chk("rd_in_present", 32'(sif.mem_rd), 32'd0);
      if (prev_pres) begin
        chk("hold_valid", 32'(sif.out_valid), 32'd1);
        chk("hold_left", 32'(sif.out_left), 32'(prev_l));
        chk("hold_right", 32'(sif.out_right), 32'(prev_r));
      end
      if (prev_xfer) begin
        chk("after_addr", 32'(sif.mem_addr), 32'(next_base));
        if (prev_en) begin
          chk("after_rd", 32'(sif.mem_rd), 32'd1);
        end else begin
          chk("idle_rd", 32'(sif.mem_rd), 32'd0);
          chk("idle_valid", 32'(sif.out_valid), 32'd0);
        end
      end
      prev_pres = 0;
      prev_xfer = 0;
      if (sif.out_valid && sif.out_ready) begin
        e = exp_q.pop_front();
        refill();
        chk("left", 32'(sif.out_left), 32'(word[e.base]));
        chk("right", 32'(sif.out_right),
            32'(word[e.base + 1]));
        chk("wrap", 32'(sif.wrap), 32'(e.wr));
        next_base = exp_q[0].base;
        prev_xfer = 1;
        prev_en   = EN;
      end else begin
        chk("wrap_quiet", 32'(sif.wrap), 32'd0);
        if (sif.out_valid) begin
          prev_pres = 1;
          prev_l    = sif.out_left;
          prev_r    = sif.out_right;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (sif.out_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("valid_timeout", 32'(ok), 32'd1);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_addr"}, 32'(sif.mem_addr), 32'd0);
    chk({tag, "_rd"}, 32'(sif.mem_rd), 32'd0);
    chk({tag, "_valid"}, 32'(sif.out_valid), 32'd0);
    chk({tag, "_left"}, 32'(sif.out_left), 32'd0);
    chk({tag, "_right"}, 32'(sif.out_right), 32'd0);
    chk({tag, "_wrap"}, 32'(sif.wrap), 32'd0);
  endtask

  initial begin
    int c0;
    int prev;
    logic [DW-1:0] hl, hr;

    clear = 1'b1;
    EN = 1'b0;
    sif.out_ready = 1'b0;
    sif.mem_rdata = '0;
    for (int a = 0; a < 256; a++) word[a] = DW'(a);
    tick();
    tick();
    chk_zero("reset");

    // Streaming at full rate, through several wraps.
    clear = 1'b0;
    EN = 1'b1;
    sif.out_ready = 1'b1;
    c0 = cyc;
    wait_valid();
    chk("first_latency", 32'(cyc - c0), 32'd4);
    for (int n = 0; n < 11; n++) begin
      prev = cyc;
      tick();
      wait_valid();
      chk("pair_interval", 32'(cyc - prev), 32'd4);
    end

    // Consumer stall while presenting.
    sif.out_ready = 1'b0;
    hl = sif.out_left;
    hr = sif.out_right;
    for (int n = 0; n < 10; n++) begin
      chk("stall_valid", 32'(sif.out_valid), 32'd1);
      chk("stall_rd", 32'(sif.mem_rd), 32'd0);
      tick();
    end
    chk("stall_left", 32'(sif.out_left), 32'(hl));
    chk("stall_right", 32'(sif.out_right), 32'(hr));
    sif.out_ready = 1'b1;
    EN = 1'b0;
    for (int n = 0; n < 4; n++) tick();

    // EN dropped while the right word is being read.
    EN = 1'b1;
    tick();
    tick();
    EN = 1'b0;
    wait_valid();
    tick();
    for (int n = 0; n < 3; n++) begin
      chk("drop_rd", 32'(sif.mem_rd), 32'd0);
      chk("drop_valid", 32'(sif.out_valid), 32'd0);
      tick();
    end

    // Clear during CAP_R discards the pair.
    EN = 1'b1;
    tick();
    tick();
    tick();
    clear = 1'b1;
    #1;
    chk_zero("midclr");
    tick();
    tick();
    clear = 1'b0;
    tick();
    chk("rst_rd_l", 32'(sif.mem_rd), 32'd1);
    chk("rst_addr_l", 32'(sif.mem_addr), 32'd0);
    tick();
    chk("rst_rd_r", 32'(sif.mem_rd), 32'd1);
    chk("rst_addr_r", 32'(sif.mem_addr), 32'd1);
    wait_valid();

    // Random EN / out_ready over random memory contents.
    clear = 1'b1;
    for (int a = 0; a < 256; a++) word[a] = DW'($urandom);
    tick();
    tick();
    clear = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      EN = ($urandom_range(0, 3) != 0);
      sif.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    EN = 1'b0;
    sif.out_ready = 1'b1;
    for (int n = 0; n < 10; n++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
